// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between instruction fetch and data memory.
// Data has priority, with a starvation guard for fetch and a hung-RAM watchdog.
module mem_arbiter #(
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int AW             = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          ihit,
    output logic [AW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic          dhit,
    output logic [AW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  logic          ram_ready,
    output logic          err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [AW-1:0] lat_addr;
    logic [AW-1:0] lat_store;
    logic          lat_wr;

    logic d_req;
    logic starved;
    logic busy_i;
    logic busy_d;

    assign d_req   = dREN | dWEN;
    assign starved = iREN && (starve_cnt == SW'(STARVE_MAX));
    assign busy_i  = (state == IBUSY);
    assign busy_d  = (state == DBUSY);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            lat_addr   <= '0;
            lat_store  <= '0;
            lat_wr     <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !starved) begin
                        lat_addr   <= daddr;
                        lat_store  <= dstore;
                        lat_wr     <= dWEN;
                        starve_cnt <= iREN ? starve_cnt + SW'(1) : '0;
                        tmo_cnt    <= '0;
                        state      <= DBUSY;
                    end else if (iREN) begin
                        lat_addr   <= iaddr;
                        lat_store  <= '0;
                        lat_wr     <= 1'b0;
                        starve_cnt <= '0;
                        tmo_cnt    <= '0;
                        state      <= IBUSY;
                    end
                end
                IBUSY, DBUSY: begin
                    // Access is atomic: only ram_ready or the watchdog ends it
                    if (ram_ready) begin
                        state <= IDLE;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ramREN   = busy_i | (busy_d & ~lat_wr);
    assign ramWEN   = busy_d & lat_wr;
    assign ramaddr  = (busy_i | busy_d) ? lat_addr : '0;
    assign ramstore = busy_d ? lat_store : '0;

    // A withdrawn request discards the completing access
    assign ihit  = busy_i & ram_ready & iREN;
    assign dhit  = busy_d & ram_ready & d_req;
    assign iload = ihit ? ramload : '0;
    assign dload = dhit ? ramload : '0;

endmodule
